afu_req_arb: RTL and testbench
==============================

# afu_req_arb

Round-robin request arbiter that shares one CCI-style read-request channel and one write-request channel among `N_REQ` user engines of the afu_user type. It sits between the user engines and the single request/response port of the AFU shell. It tags each issued request with the requester ID in the top mdata bits and steers each read or write response back to the requester that issued it. It also tracks outstanding transactions and aggregates per-engine done flags.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester-ID width; must satisfy 2^ID_W >= N_REQ.
- `ADDR_LMT`, 20: cache-line address width.
- `MDATA`, 14: mdata width; bits [MDATA-1 -: ID_W] carry the ID.
- `CACHE_WIDTH`, 512: data width.
- `OUT_W`, 8: outstanding-counter width.

Ports (the clock is `clk`; reset is `reset`, which is synchronous and active-high). Vectors ending in `_in`/`_out` are flattened per requester, with requester k at slice k.
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `u_rd_req_en` in N_REQ: per-requester read request strobe.
- `u_rd_req_addr` in N_REQ*ADDR_LMT: read addresses.
- `u_rd_req_mdata` in N_REQ*MDATA: user mdata; ID bits are ignored.
- `u_rd_req_almostfull` out N_REQ: read backpressure to each requester.
- `u_wr_req_en` in N_REQ: write request strobe.
- `u_wr_req_addr` in N_REQ*ADDR_LMT: write addresses.
- `u_wr_req_mdata` in N_REQ*MDATA: write mdata.
- `u_wr_req_data` in N_REQ*CACHE_WIDTH: write data.
- `u_wr_req_almostfull` out N_REQ: write backpressure.
- `u_rd_rsp_valid` out N_REQ: steered read response valid.
- `u_rd_rsp_mdata` out MDATA: response mdata with ID field zeroed; shared by all requesters.
- `u_rd_rsp_data` out CACHE_WIDTH: read response data; shared by all requesters.
- `u_wr_rsp0_valid`, `u_wr_rsp1_valid` out N_REQ: steered write responses.
- `u_wr_rsp0_mdata`, `u_wr_rsp1_mdata` out MDATA: write response mdata with ID zeroed.
- `u_done` in N_REQ: per-engine done.
- `rd_req_en`, `rd_req_addr`, `rd_req_mdata` out 1/ADDR_LMT/MDATA: shell read request.
- `rd_req_almostfull` in 1: shell read backpressure.
- `rd_rsp_valid`, `rd_rsp_mdata`, `rd_rsp_data` in 1/MDATA/CACHE_WIDTH: shell read response.
- `wr_req_en`, `wr_req_addr`, `wr_req_mdata`, `wr_req_data` out: shell write request.
- `wr_req_almostfull` in 1: shell write backpressure.
- `wr_rsp0_valid`, `wr_rsp0_mdata`, `wr_rsp1_valid`, `wr_rsp1_mdata` in: shell write responses.
- `rd_outstanding`, `wr_outstanding` out OUT_W: in-flight request counts.
- `idle` out 1: all hold registers are empty and both outstanding counts are 0.
- `all_done` out 1: registered AND of `u_done`.
- `err_overrun` out N_REQ: sticky flag; bit k sets when requester k strobes while its hold register is full.

## Operation
- Each requester has one hold register for reads and one for writes. A strobe loads the hold register when it is empty.
- `u_*_almostfull[k]` is combinational: `hold_valid[k]` OR shell almostfull.
- A strobe while the hold register is full is dropped, and `err_overrun[k]` is set. The flag clears only on reset.
- Each channel has an independent round-robin arbiter. When the shell almostfull is low and any hold register is valid, it grants the first valid requester searching from last_grant+1 modulo N_REQ.
- The grant loads the shell output registers and clears the granted hold register on the same edge. At most one issue per channel per cycle.
- Issued mdata = user mdata with bits [MDATA-1 -: ID_W] replaced by the grant ID.
- Responses are steered by ID: `u_rd_rsp_valid[id]` = 1. Data and mdata are registered with the ID field zeroed. IDs >= N_REQ are discarded and counted as completed.
- Counters: `rd_outstanding` increments on issue and decrements on `rd_rsp_valid`.
  - `wr_outstanding` increments on issue and decrements by the number of write-response valids in the cycle (0, 1 or 2).
  - A simultaneous increment and decrement nets out. Counters saturate at 0 and at all-ones.

## Timing
- Reset values: all `_en` and `_valid` outputs 0; addr/mdata/data 0; hold registers empty; last_grant = N_REQ-1, so requester 0 wins first; counters 0; `err_overrun` 0; `all_done` 0; `idle` 1.
- Request latency: strobe in cycle T is held at edge T, granted in T+1, and appears at the shell with `rd_req_en`/`wr_req_en` high for exactly one cycle in T+2, provided almostfull is low in T+1.
- Per requester: one request every 2 cycles at most. Aggregate: one request per cycle per channel.
- Shell almostfull sampled high in cycle T means no grant in T. Hold registers retain their contents and no request is lost.
- Response latency: 1 cycle, registered.
- `rsp0` and `rsp1` for the same ID in the same cycle both assert on their own ports.
- Reset mid-operation clears the hold registers and counters. In-flight shell responses that arrive after reset are steered but do not decrement below 0.

## Test plan
- Single requester: requester 2 strobes a read at addr 0x00010 in cycle 5 → shell `rd_req_en` in cycle 7, addr 0x00010, mdata[13:12]=2'b10. A response with that mdata → `u_rd_rsp_valid`=4'b0100 one cycle later, and `rd_outstanding` goes 0→1→0.
- Fairness: all 4 requesters keep reads pending continuously → grant order 0,1,2,3,0,…, with no requester skipped over 16 issues.
- Backpressure: `wr_req_almostfull` held high for 10 cycles with 3 writes held → zero `wr_req_en` during that window. After release the 3 writes issue on consecutive cycles with data intact.
- Overrun: requester 1 strobes on 2 consecutive cycles while almostfull is high → the second request is dropped, `err_overrun`=4'b0010, and only 1 request issues.
- Dual write response: `wr_rsp0_valid` and `wr_rsp1_valid` in the same cycle for IDs 0 and 3 with `wr_outstanding`=2 → count becomes 0, and `u_wr_rsp0_valid`=0001 and `u_wr_rsp1_valid`=1000.
- Done and reset: `u_done` rises one bit per cycle → `all_done` rises 1 cycle after the last bit. Reset asserted with 2 reads outstanding → counters 0, `idle`=1, `all_done`=0 the next cycle.

Source files
------------

// File: rtl/afu_req_arb.sv
// afu_req_arb: shares one read and one write request channel among N_REQ engines
// with round-robin arbitration, ID-tagged mdata, response steering and in-flight counts.
module afu_req_arb #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int OUT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             u_rd_req_en,
  input  logic [N_REQ*ADDR_LMT-1:0]    u_rd_req_addr,
  input  logic [N_REQ*MDATA-1:0]       u_rd_req_mdata,
  output logic [N_REQ-1:0]             u_rd_req_almostfull,
  input  logic [N_REQ-1:0]             u_wr_req_en,
  input  logic [N_REQ*ADDR_LMT-1:0]    u_wr_req_addr,
  input  logic [N_REQ*MDATA-1:0]       u_wr_req_mdata,
  input  logic [N_REQ*CACHE_WIDTH-1:0] u_wr_req_data,
  output logic [N_REQ-1:0]             u_wr_req_almostfull,
  output logic [N_REQ-1:0]             u_rd_rsp_valid,
  output logic [MDATA-1:0]             u_rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0]       u_rd_rsp_data,
  output logic [N_REQ-1:0]             u_wr_rsp0_valid,
  output logic [N_REQ-1:0]             u_wr_rsp1_valid,
  output logic [MDATA-1:0]             u_wr_rsp0_mdata,
  output logic [MDATA-1:0]             u_wr_rsp1_mdata,
  input  logic [N_REQ-1:0]             u_done,
  output logic                         rd_req_en,
  output logic [ADDR_LMT-1:0]          rd_req_addr,
  output logic [MDATA-1:0]             rd_req_mdata,
  input  logic                         rd_req_almostfull,
  input  logic                         rd_rsp_valid,
  input  logic [MDATA-1:0]             rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0]       rd_rsp_data,
  output logic                         wr_req_en,
  output logic [ADDR_LMT-1:0]          wr_req_addr,
  output logic [MDATA-1:0]             wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]       wr_req_data,
  input  logic                         wr_req_almostfull,
  input  logic                         wr_rsp0_valid,
  input  logic [MDATA-1:0]             wr_rsp0_mdata,
  input  logic                         wr_rsp1_valid,
  input  logic [MDATA-1:0]             wr_rsp1_mdata,
  output logic [OUT_W-1:0]             rd_outstanding,
  output logic [OUT_W-1:0]             wr_outstanding,
  output logic                         idle,
  output logic                         all_done,
  output logic [N_REQ-1:0]             err_overrun
);

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req[k] && (((int'(last) + off) % N_REQ) == k)) begin
          pick  = ID_W'(k);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [MDATA-1:0] id_tag(input logic [MDATA-1:0] m, input logic [ID_W-1:0] id);
    logic [MDATA-1:0] r;
    r = m;
    r[MDATA-1 -: ID_W] = id;
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] steer(input logic v, input logic [MDATA-1:0] m);
    logic [N_REQ-1:0] oh;
    for (int k = 0; k < N_REQ; k++) begin
      oh[k] = v && (m[MDATA-1 -: ID_W] == ID_W'(k));
    end
    return oh;
  endfunction

  // Saturating count update: dec may be 0..2 write completions in one cycle.
  function automatic logic [OUT_W-1:0] sat_next(input logic [OUT_W-1:0] cnt, input logic inc, input logic [1:0] dec);
    logic [OUT_W+1:0] sum;
    logic [OUT_W-1:0] r;
    sum = {2'b00, cnt} + {{(OUT_W+1){1'b0}}, inc};
    if (sum < {{OUT_W{1'b0}}, dec}) begin
      r = '0;
    end else if ((sum - {{OUT_W{1'b0}}, dec}) > {2'b00, {OUT_W{1'b1}}}) begin
      r = '1;
    end else begin
      r = sum[OUT_W-1:0] - {{(OUT_W-2){1'b0}}, dec};
    end
    return r;
  endfunction

  logic [N_REQ-1:0]       rd_hold_v_q, wr_hold_v_q, err_q;
  logic [ADDR_LMT-1:0]    rd_addr_q [N_REQ];
  logic [MDATA-1:0]       rd_mdata_q [N_REQ];
  logic [ADDR_LMT-1:0]    wr_addr_q [N_REQ];
  logic [MDATA-1:0]       wr_mdata_q [N_REQ];
  logic [CACHE_WIDTH-1:0] wr_data_q [N_REQ];
  logic [ID_W-1:0]        rd_last_q, wr_last_q, rd_gnt_id_d, wr_gnt_id_d;
  logic                   rd_gnt_d, wr_gnt_d;
  logic [ADDR_LMT-1:0]    rd_sel_addr_d, wr_sel_addr_d;
  logic [MDATA-1:0]       rd_sel_mdata_d, wr_sel_mdata_d;
  logic [CACHE_WIDTH-1:0] wr_sel_data_d;
  logic [OUT_W-1:0]       rd_out_q, wr_out_q, rd_out_d, wr_out_d;
  logic                   all_done_q;

  assign rd_gnt_d    = (|rd_hold_v_q) && !rd_req_almostfull;
  assign wr_gnt_d    = (|wr_hold_v_q) && !wr_req_almostfull;
  assign rd_gnt_id_d = rr_pick(rd_hold_v_q, rd_last_q);
  assign wr_gnt_id_d = rr_pick(wr_hold_v_q, wr_last_q);
  assign rd_out_d    = sat_next(rd_out_q, rd_gnt_d, {1'b0, rd_rsp_valid});
  assign wr_out_d    = sat_next(wr_out_q, wr_gnt_d, {1'b0, wr_rsp0_valid} + {1'b0, wr_rsp1_valid});

  // Select the granted requester's held request.
  always_comb begin
    rd_sel_addr_d  = '0;
    rd_sel_mdata_d = '0;
    wr_sel_addr_d  = '0;
    wr_sel_mdata_d = '0;
    wr_sel_data_d  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rd_sel_addr_d  |= (rd_gnt_id_d == ID_W'(k)) ? rd_addr_q[k]  : '0;
      rd_sel_mdata_d |= (rd_gnt_id_d == ID_W'(k)) ? rd_mdata_q[k] : '0;
      wr_sel_addr_d  |= (wr_gnt_id_d == ID_W'(k)) ? wr_addr_q[k]  : '0;
      wr_sel_mdata_d |= (wr_gnt_id_d == ID_W'(k)) ? wr_mdata_q[k] : '0;
      wr_sel_data_d  |= (wr_gnt_id_d == ID_W'(k)) ? wr_data_q[k]  : '0;
    end
  end

  // Hold registers: load when empty, clear on grant, flag strobes that find them full.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hold_v_q <= '0;
      wr_hold_v_q <= '0;
      err_q       <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        rd_addr_q[k]  <= '0;
        rd_mdata_q[k] <= '0;
        wr_addr_q[k]  <= '0;
        wr_mdata_q[k] <= '0;
        wr_data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if ((u_rd_req_en[k] && rd_hold_v_q[k]) || (u_wr_req_en[k] && wr_hold_v_q[k])) begin
          err_q[k] <= 1'b1;
        end
        if (rd_gnt_d && (rd_gnt_id_d == ID_W'(k))) begin
          rd_hold_v_q[k] <= 1'b0;
        end else if (u_rd_req_en[k] && !rd_hold_v_q[k]) begin
          rd_hold_v_q[k] <= 1'b1;
          rd_addr_q[k]   <= u_rd_req_addr[k*ADDR_LMT +: ADDR_LMT];
          rd_mdata_q[k]  <= u_rd_req_mdata[k*MDATA +: MDATA];
        end
        if (wr_gnt_d && (wr_gnt_id_d == ID_W'(k))) begin
          wr_hold_v_q[k] <= 1'b0;
        end else if (u_wr_req_en[k] && !wr_hold_v_q[k]) begin
          wr_hold_v_q[k] <= 1'b1;
          wr_addr_q[k]   <= u_wr_req_addr[k*ADDR_LMT +: ADDR_LMT];
          wr_mdata_q[k]  <= u_wr_req_mdata[k*MDATA +: MDATA];
          wr_data_q[k]   <= u_wr_req_data[k*CACHE_WIDTH +: CACHE_WIDTH];
        end
      end
    end
  end

  // Shell request registers, grant pointers and outstanding counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req_en    <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      wr_req_en    <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_mdata <= '0;
      wr_req_data  <= '0;
      rd_last_q    <= ID_W'(N_REQ - 1);
      wr_last_q    <= ID_W'(N_REQ - 1);
      rd_out_q     <= '0;
      wr_out_q     <= '0;
      all_done_q   <= 1'b0;
    end else begin
      rd_req_en  <= rd_gnt_d;
      wr_req_en  <= wr_gnt_d;
      rd_out_q   <= rd_out_d;
      wr_out_q   <= wr_out_d;
      all_done_q <= &u_done;
      if (rd_gnt_d) begin
        rd_req_addr  <= rd_sel_addr_d;
        rd_req_mdata <= id_tag(rd_sel_mdata_d, rd_gnt_id_d);
        rd_last_q    <= rd_gnt_id_d;
      end
      if (wr_gnt_d) begin
        wr_req_addr  <= wr_sel_addr_d;
        wr_req_mdata <= id_tag(wr_sel_mdata_d, wr_gnt_id_d);
        wr_req_data  <= wr_sel_data_d;
        wr_last_q    <= wr_gnt_id_d;
      end
    end
  end

  // Response steering; unknown IDs produce no valid but still count as completed.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_rd_rsp_valid  <= '0;
      u_rd_rsp_mdata  <= '0;
      u_rd_rsp_data   <= '0;
      u_wr_rsp0_valid <= '0;
      u_wr_rsp0_mdata <= '0;
      u_wr_rsp1_valid <= '0;
      u_wr_rsp1_mdata <= '0;
    end else begin
      u_rd_rsp_valid  <= steer(rd_rsp_valid, rd_rsp_mdata);
      u_rd_rsp_mdata  <= id_tag(rd_rsp_mdata, '0);
      u_rd_rsp_data   <= rd_rsp_data;
      u_wr_rsp0_valid <= steer(wr_rsp0_valid, wr_rsp0_mdata);
      u_wr_rsp0_mdata <= id_tag(wr_rsp0_mdata, '0);
      u_wr_rsp1_valid <= steer(wr_rsp1_valid, wr_rsp1_mdata);
      u_wr_rsp1_mdata <= id_tag(wr_rsp1_mdata, '0);
    end
  end

  assign u_rd_req_almostfull = rd_hold_v_q | {N_REQ{rd_req_almostfull}};
  assign u_wr_req_almostfull = wr_hold_v_q | {N_REQ{wr_req_almostfull}};
  assign rd_outstanding      = rd_out_q;
  assign wr_outstanding      = wr_out_q;
  assign err_overrun         = err_q;
  assign all_done            = all_done_q;
  assign idle = ~(|rd_hold_v_q) & ~(|wr_hold_v_q) & (rd_out_q == '0) & (wr_out_q == '0);

endmodule

// File: tb/tb_afu_req_arb.sv
// Bench for afu_req_arb: directed scenarios, a response-steering table and a
// randomized run, all checked against a queue-of-slots reference model.
module tb_afu_req_arb;
  localparam int N = 4, IDW = 2, AW = 20, MW = 14, CW = 512, OW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [N-1:0] u_rd_req_en, u_wr_req_en, u_done;
  logic [N*AW-1:0] u_rd_req_addr, u_wr_req_addr;
  logic [N*MW-1:0] u_rd_req_mdata, u_wr_req_mdata;
  logic [N*CW-1:0] u_wr_req_data;
  logic rd_req_almostfull, wr_req_almostfull, rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid;
  logic [MW-1:0] rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic [CW-1:0] rd_rsp_data;
  logic [N-1:0] u_rd_req_almostfull, u_wr_req_almostfull, u_rd_rsp_valid, u_wr_rsp0_valid, u_wr_rsp1_valid, err_overrun;
  logic [MW-1:0] u_rd_rsp_mdata, u_wr_rsp0_mdata, u_wr_rsp1_mdata, rd_req_mdata, wr_req_mdata;
  logic [CW-1:0] u_rd_rsp_data, wr_req_data;
  logic rd_req_en, wr_req_en, idle, all_done;
  logic [AW-1:0] rd_req_addr, wr_req_addr;
  logic [OW-1:0] rd_outstanding, wr_outstanding;

  afu_req_arb #(.N_REQ(N), .ID_W(IDW), .ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(CW), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset),
    .u_rd_req_en(u_rd_req_en), .u_rd_req_addr(u_rd_req_addr), .u_rd_req_mdata(u_rd_req_mdata),
    .u_rd_req_almostfull(u_rd_req_almostfull),
    .u_wr_req_en(u_wr_req_en), .u_wr_req_addr(u_wr_req_addr), .u_wr_req_mdata(u_wr_req_mdata),
    .u_wr_req_data(u_wr_req_data), .u_wr_req_almostfull(u_wr_req_almostfull),
    .u_rd_rsp_valid(u_rd_rsp_valid), .u_rd_rsp_mdata(u_rd_rsp_mdata), .u_rd_rsp_data(u_rd_rsp_data),
    .u_wr_rsp0_valid(u_wr_rsp0_valid), .u_wr_rsp1_valid(u_wr_rsp1_valid),
    .u_wr_rsp0_mdata(u_wr_rsp0_mdata), .u_wr_rsp1_mdata(u_wr_rsp1_mdata),
    .u_done(u_done),
    .rd_req_en(rd_req_en), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_en(wr_req_en), .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .idle(idle), .all_done(all_done), .err_overrun(err_overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one pending slot per requester and channel, plain integer counters.
  logic [N-1:0]  m_rd_p, m_wr_p, e_err, e_urv, e_uw0, e_uw1;
  logic [AW-1:0] m_rd_a [N], m_wr_a [N];
  logic [MW-1:0] m_rd_m [N], m_wr_m [N];
  logic [CW-1:0] m_wr_d [N];
  int m_rd_last, m_wr_last, m_rd_cnt, m_wr_cnt;
  logic e_rd_en, e_wr_en, e_done;
  logic [AW-1:0] e_rd_a, e_wr_a;
  logic [MW-1:0] e_rd_m, e_wr_m, e_urm, e_uw0m, e_uw1m;
  logic [CW-1:0] e_wr_d, e_urd;

  function automatic logic [MW-1:0] tag(input logic [MW-1:0] m, input int id);
    int v;
    v = (int'(m) % 4096) + id * 4096;
    return v[MW-1:0];
  endfunction

  function automatic int id_of(input logic [MW-1:0] m);
    return int'(m) / 4096;
  endfunction

  function automatic int pick(input logic [N-1:0] p, input int last);
    for (int i = 1; i <= N; i++) begin
      if (p[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [CW-1:0] rnd_data();
    logic [CW-1:0] d;
    for (int i = 0; i < CW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_rd_p = '0; m_wr_p = '0; e_err = '0; e_urv = '0; e_uw0 = '0; e_uw1 = '0;
    m_rd_last = N - 1; m_wr_last = N - 1; m_rd_cnt = 0; m_wr_cnt = 0;
    e_rd_en = 1'b0; e_wr_en = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] rp_old, wp_old;
    int rg, wg;
    rp_old = m_rd_p;
    wp_old = m_wr_p;
    if (reset) begin
      model_reset();
    end else begin
      rg = rd_req_almostfull ? -1 : pick(rp_old, m_rd_last);
      wg = wr_req_almostfull ? -1 : pick(wp_old, m_wr_last);
      e_rd_en = (rg >= 0);
      e_wr_en = (wg >= 0);
      if (rg >= 0) begin
        e_rd_a = m_rd_a[rg]; e_rd_m = tag(m_rd_m[rg], rg); m_rd_p[rg] = 1'b0; m_rd_last = rg;
      end
      if (wg >= 0) begin
        e_wr_a = m_wr_a[wg]; e_wr_m = tag(m_wr_m[wg], wg); e_wr_d = m_wr_d[wg];
        m_wr_p[wg] = 1'b0; m_wr_last = wg;
      end
      for (int k = 0; k < N; k++) begin
        if (u_rd_req_en[k] && rp_old[k]) e_err[k] = 1'b1;
        if (u_wr_req_en[k] && wp_old[k]) e_err[k] = 1'b1;
        if (u_rd_req_en[k] && !rp_old[k]) begin
          m_rd_p[k] = 1'b1; m_rd_a[k] = u_rd_req_addr[k*AW +: AW]; m_rd_m[k] = u_rd_req_mdata[k*MW +: MW];
        end
        if (u_wr_req_en[k] && !wp_old[k]) begin
          m_wr_p[k] = 1'b1; m_wr_a[k] = u_wr_req_addr[k*AW +: AW]; m_wr_m[k] = u_wr_req_mdata[k*MW +: MW];
          m_wr_d[k] = u_wr_req_data[k*CW +: CW];
        end
      end
      m_rd_cnt = clampc(m_rd_cnt + int'(e_rd_en) - int'(rd_rsp_valid));
      m_wr_cnt = clampc(m_wr_cnt + int'(e_wr_en) - int'(wr_rsp0_valid) - int'(wr_rsp1_valid));
      e_urv = '0; e_uw0 = '0; e_uw1 = '0;
      if (rd_rsp_valid && id_of(rd_rsp_mdata) < N) e_urv[id_of(rd_rsp_mdata)] = 1'b1;
      if (wr_rsp0_valid && id_of(wr_rsp0_mdata) < N) e_uw0[id_of(wr_rsp0_mdata)] = 1'b1;
      if (wr_rsp1_valid && id_of(wr_rsp1_mdata) < N) e_uw1[id_of(wr_rsp1_mdata)] = 1'b1;
      e_urm = tag(rd_rsp_mdata, 0); e_urd = rd_rsp_data;
      e_uw0m = tag(wr_rsp0_mdata, 0); e_uw1m = tag(wr_rsp1_mdata, 0);
      e_done = &u_done;
    end
  endtask

  task automatic compare_all();
    chk("rd_req_en", rd_req_en, e_rd_en);
    if (e_rd_en) begin
      chk("rd_req_addr", rd_req_addr, e_rd_a);
      chk("rd_req_mdata", rd_req_mdata, e_rd_m);
    end
    chk("wr_req_en", wr_req_en, e_wr_en);
    if (e_wr_en) begin
      chk("wr_req_addr", wr_req_addr, e_wr_a);
      chk("wr_req_mdata", wr_req_mdata, e_wr_m);
      chk("wr_req_data", wr_req_data, e_wr_d);
    end
    chk("rd_outstanding", rd_outstanding, m_rd_cnt);
    chk("wr_outstanding", wr_outstanding, m_wr_cnt);
    chk("u_rd_rsp_valid", u_rd_rsp_valid, e_urv);
    if (e_urv != '0) begin
      chk("u_rd_rsp_mdata", u_rd_rsp_mdata, e_urm);
      chk("u_rd_rsp_data", u_rd_rsp_data, e_urd);
    end
    chk("u_wr_rsp0_valid", u_wr_rsp0_valid, e_uw0);
    if (e_uw0 != '0) chk("u_wr_rsp0_mdata", u_wr_rsp0_mdata, e_uw0m);
    chk("u_wr_rsp1_valid", u_wr_rsp1_valid, e_uw1);
    if (e_uw1 != '0) chk("u_wr_rsp1_mdata", u_wr_rsp1_mdata, e_uw1m);
    chk("err_overrun", err_overrun, e_err);
    chk("all_done", all_done, e_done);
    chk("idle", idle, (m_rd_p == '0) && (m_wr_p == '0) && (m_rd_cnt == 0) && (m_wr_cnt == 0));
  endtask

  // Called just after an active edge with inputs for the coming cycle already driven.
  task automatic tick();
    #1;
    chk("u_rd_req_almostfull", u_rd_req_almostfull, m_rd_p | {N{rd_req_almostfull}});
    chk("u_wr_req_almostfull", u_wr_req_almostfull, m_wr_p | {N{wr_req_almostfull}});
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    u_rd_req_en = '0; u_wr_req_en = '0;
    u_rd_req_addr = '0; u_wr_req_addr = '0; u_rd_req_mdata = '0; u_wr_req_mdata = '0; u_wr_req_data = '0;
    rd_req_almostfull = 1'b0; wr_req_almostfull = 1'b0;
    rd_rsp_valid = 1'b0; wr_rsp0_valid = 1'b0; wr_rsp1_valid = 1'b0;
    rd_rsp_mdata = '0; wr_rsp0_mdata = '0; wr_rsp1_mdata = '0; rd_rsp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic rv; int rid; logic w0v; int w0id; logic w1v; int w1id;
    logic [N-1:0] er; logic [N-1:0] e0; logic [N-1:0] e1;
  } rsp_vec_t;

  rsp_vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ord [3];
    int n, prev, first, id, cnt;
    logic [CW-1:0] wd [N];
    tbl[0] = '{1'b1, 0, 1'b0, 0, 1'b0, 0, 4'b0001, 4'b0000, 4'b0000};
    tbl[1] = '{1'b1, 3, 1'b1, 1, 1'b0, 0, 4'b1000, 4'b0010, 4'b0000};
    tbl[2] = '{1'b0, 2, 1'b1, 2, 1'b1, 2, 4'b0000, 4'b0100, 4'b0100};
    tbl[3] = '{1'b1, 1, 1'b0, 3, 1'b1, 0, 4'b0010, 4'b0000, 4'b0001};
    tbl[4] = '{1'b0, 0, 1'b0, 1, 1'b0, 2, 4'b0000, 4'b0000, 4'b0000};
    tbl[5] = '{1'b1, 2, 1'b1, 3, 1'b1, 1, 4'b0100, 4'b1000, 4'b0010};

    reset = 1'b1; u_done = '0;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    compare_all();
    chk("reset_rd_en", rd_req_en, 1'b0);
    chk("reset_idle", idle, 1'b1);
    chk("reset_err", err_overrun, 4'b0000);
    chk("reset_all_done", all_done, 1'b0);
    reset = 1'b0;

    // Single requester read and its response.
    tick(); tick();
    u_rd_req_en[2] = 1'b1; u_rd_req_addr[2*AW +: AW] = 20'h00010; u_rd_req_mdata[2*MW +: MW] = 14'h3abc;
    tick();
    clear_inputs();
    tick();
    chk("single_en", rd_req_en, 1'b1);
    chk("single_addr", rd_req_addr, 20'h00010);
    chk("single_id", rd_req_mdata[13:12], 2'b10);
    chk("single_mdata", rd_req_mdata, 14'h2abc);
    chk("single_out1", rd_outstanding, 8'd1);
    tick();
    chk("single_en_one_cycle", rd_req_en, 1'b0);
    rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'h2abc; rd_rsp_data = {16{32'hc0ffee01}};
    tick();
    clear_inputs();
    chk("single_rsp_valid", u_rd_rsp_valid, 4'b0100);
    chk("single_rsp_mdata", u_rd_rsp_mdata, 14'h0abc);
    chk("single_rsp_data", u_rd_rsp_data, {16{32'hc0ffee01}});
    chk("single_out0", rd_outstanding, 8'd0);

    // Fairness with every requester keeping a read pending.
    cnt = 0; prev = 0; first = -1;
    for (int c = 0; c < 40 && cnt < 16; c++) begin
      for (int k = 0; k < N; k++) begin
        u_rd_req_en[k] = !u_rd_req_almostfull[k];
        u_rd_req_addr[k*AW +: AW] = AW'(k * 256 + c);
      end
      tick();
      if (rd_req_en) begin
        id = int'(rd_req_mdata[13:12]);
        if (first < 0) first = id;
        else chk("rr_order", id, (prev + 1) % N);
        prev = id;
        cnt++;
      end
    end
    clear_inputs();
    chk("rr_first", first, 3);
    chk("rr_issue_count", cnt, 16);
    chk("rr_no_overrun", err_overrun, 4'b0000);

    // Write backpressure for 10 cycles with three writes held.
    do_reset();
    wr_req_almostfull = 1'b1;
    ord[0] = 0; ord[1] = 1; ord[2] = 3;
    for (int i = 0; i < 3; i++) begin
      wd[ord[i]] = rnd_data();
      u_wr_req_en[ord[i]] = 1'b1;
      u_wr_req_addr[ord[i]*AW +: AW] = AW'(20'h00100 + ord[i]);
      u_wr_req_data[ord[i]*CW +: CW] = wd[ord[i]];
    end
    tick();
    u_wr_req_en = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_no_wr", wr_req_en, 1'b0);
    end
    wr_req_almostfull = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_wr_en", wr_req_en, 1'b1);
      chk("bp_wr_id", wr_req_mdata[13:12], ord[i]);
      chk("bp_wr_data", wr_req_data, wd[ord[i]]);
    end
    tick();
    chk("bp_wr_done", wr_req_en, 1'b0);

    // Overrun: second strobe dropped while the shell is full.
    do_reset();
    rd_req_almostfull = 1'b1;
    u_rd_req_en[1] = 1'b1; u_rd_req_addr[1*AW +: AW] = 20'h0aaaa;
    tick();
    u_rd_req_addr[1*AW +: AW] = 20'h0bbbb;
    tick();
    u_rd_req_en = '0;
    chk("ovr_flag", err_overrun, 4'b0010);
    rd_req_almostfull = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_req_en) begin
        n++;
        chk("ovr_addr", rd_req_addr, 20'h0aaaa);
      end
    end
    chk("ovr_issue_count", n, 1);

    // Dual write response in one cycle.
    u_wr_req_en = 4'b1001;
    tick();
    u_wr_req_en = '0;
    n = 0;
    while (wr_outstanding != 8'd2 && n < 10) begin tick(); n++; end
    chk("dual_wr_out2", wr_outstanding, 8'd2);
    wr_rsp0_valid = 1'b1; wr_rsp0_mdata = 14'h0123;
    wr_rsp1_valid = 1'b1; wr_rsp1_mdata = 14'h3456;
    tick();
    clear_inputs();
    chk("dual_wr_out0", wr_outstanding, 8'd0);
    chk("dual_rsp0", u_wr_rsp0_valid, 4'b0001);
    chk("dual_rsp1", u_wr_rsp1_valid, 4'b1000);
    chk("dual_rsp1_mdata", u_wr_rsp1_mdata, 14'h0456);

    // Done aggregation, then reset with reads in flight.
    do_reset();
    for (int i = 0; i < N; i++) begin
      u_done[i] = 1'b1;
      tick();
      chk("done_rise", all_done, (i == N - 1));
    end
    u_rd_req_en = 4'b0011;
    tick();
    u_rd_req_en = '0;
    n = 0;
    while (rd_outstanding != 8'd2 && n < 10) begin tick(); n++; end
    chk("rst_rd_out2", rd_outstanding, 8'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rd_out0", rd_outstanding, 8'd0);
    chk("rst_wr_out0", wr_outstanding, 8'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_all_done", all_done, 1'b0);
    u_done = '0;
    tick();

    // Response steering table.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rd_rsp_valid = tbl[i].rv;  rd_rsp_mdata  = tag(14'h0155, tbl[i].rid);
      wr_rsp0_valid = tbl[i].w0v; wr_rsp0_mdata = tag(14'h0a0a, tbl[i].w0id);
      wr_rsp1_valid = tbl[i].w1v; wr_rsp1_mdata = tag(14'h0505, tbl[i].w1id);
      rd_rsp_data = {16{$urandom}};
      tick();
      chk("tbl_rd_valid", u_rd_rsp_valid, tbl[i].er);
      chk("tbl_wr0_valid", u_wr_rsp0_valid, tbl[i].e0);
      chk("tbl_wr1_valid", u_wr_rsp1_valid, tbl[i].e1);
    end
    clear_inputs();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        u_rd_req_en[k] = ($urandom_range(0, 3) == 0);
        u_wr_req_en[k] = ($urandom_range(0, 3) == 0);
        u_rd_req_addr[k*AW +: AW] = AW'($urandom);
        u_wr_req_addr[k*AW +: AW] = AW'($urandom);
        u_rd_req_mdata[k*MW +: MW] = MW'($urandom);
        u_wr_req_mdata[k*MW +: MW] = MW'($urandom);
        u_wr_req_data[k*CW +: CW] = rnd_data();
      end
      rd_req_almostfull = ($urandom_range(0, 3) == 0);
      wr_req_almostfull = ($urandom_range(0, 3) == 0);
      rd_rsp_valid = ($urandom_range(0, 2) == 0); rd_rsp_mdata = MW'($urandom); rd_rsp_data = rnd_data();
      wr_rsp0_valid = ($urandom_range(0, 2) == 0); wr_rsp0_mdata = MW'($urandom);
      wr_rsp1_valid = ($urandom_range(0, 2) == 0); wr_rsp1_mdata = MW'($urandom);
      u_done = N'($urandom);
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
